// File: rtl/alu_pkg.sv
// Shared ALU select encodings, arbiter FSM states and helpers for the shared-ALU front end.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    XOR   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    OR    = 4'd8,
    AND   = 4'd9,
    PASSB = 4'd10,
    ADD4  = 4'd11
  } alu_op_t;

  localparam logic [OP_W-1:0] ALU_OP_MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Codes above the last defined op are reserved and flagged as errors.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester and response channel bundle between the execute-stage clients and the ALU arbiter.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [XLEN-1:0]         rsp_data;
  logic                    rsp_err;

  // Client side: requesters plus the response consumer.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               grant_any_c
);

  always_comb begin : scan
    int unsigned cand;
    cand        = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    // The pointer itself is visited last, so the previous winner has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!grant_any_c && req[IDX_W'(cand)]) begin
        grant_any_c              = 1'b1;
        grant_idx_c              = IDX_W'(cand);
        grant_c[IDX_W'(cand)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters with a
// registered operand bus and a tagged valid/ready response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arbiter_if.slave    bus,
  output logic [OP_W-1:0]       alu_sel,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  input  logic [XLEN-1:0]       alu_result
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [OP_W-1:0] alu_sel_q, alu_sel_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic               grant_any_c;
  logic               open_c;
  logic               accept_c;
  logic               sel_illegal_c;

  logic [OP_W-1:0] op_arr [NUM_REQ];
  logic [XLEN-1:0] a_arr  [NUM_REQ];
  logic [XLEN-1:0] b_arr  [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req         (bus.req_valid),
    .ptr         (rr_ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Split the packed requester buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_arr[i] = bus.req_op[i*OP_W +: OP_W];
      a_arr[i]  = bus.req_a[i*XLEN +: XLEN];
      b_arr[i]  = bus.req_b[i*XLEN +: XLEN];
    end
  end

  // A new op can be taken when idle, or when the held response is consumed this cycle.
  assign open_c        = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept_c      = open_c && grant_any_c;
  assign sel_illegal_c = op_illegal(alu_sel_q);
  assign bus.req_ready = open_c ? grant_c : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept_c) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = accept_c ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and response next values.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (state_q == EXEC) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_err_d   = sel_illegal_c;
      rsp_data_d  = sel_illegal_c ? '0 : alu_result;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    // Operand bus only moves on accept, so it stays quiet between ops.
    if (accept_c) begin
      rr_ptr_d  = grant_idx_c;
      id_d      = grant_idx_c;
      alu_sel_d = op_arr[grant_idx_c];
      alu_a_d   = a_arr[grant_idx_c];
      alu_b_d   = b_arr[grant_idx_c];
    end
  end

  // Datapath and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_sel      = alu_sel_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random checks of the shared-ALU arbiter against a combinational ALU model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;

  int checks = 0;
  int fails  = 0;
  int exp_g [5] = '{0, 1, 2, 3, 0};
  int wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] acc;
  exp_t exp_q [$];

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return {31'b0, $signed(a) < $signed(b)};
      4'd4:    return {31'b0, a < b};
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      4'd11:   return a + 32'd4;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    bus.req_op[i*4 +: 4]       = op;
    bus.req_a[i*XLEN +: XLEN]  = a;
    bus.req_b[i*XLEN +: XLEN]  = b;
  endtask

  // Scoreboard step at the sample point: consume responses, record accepts, bound waits.
  task automatic sb_step();
    exp_t e;
    logic [3:0] op;
    acc = bus.req_valid & bus.req_ready;
    chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rnd_id",   64'(bus.rsp_id),   64'(e.id));
        chk("rnd_data", 64'(bus.rsp_data), 64'(e.data));
        chk("rnd_err",  64'(bus.rsp_err),  64'(e.err));
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (acc[i]) begin
        op     = bus.req_op[i*4 +: 4];
        e.id   = ID_W'(i);
        e.err  = (op > 4'd11);
        e.data = e.err ? 32'd0 : alu_f(op, bus.req_a[i*XLEN +: XLEN], bus.req_b[i*XLEN +: XLEN]);
        exp_q.push_back(e);
        wait_cnt[i] = 0;
      end else if (bus.req_valid[i]) begin
        if (acc != '0) wait_cnt[i]++;
        chk("wait_bound", 64'(wait_cnt[i] <= int'(NUM_REQ)), 64'd1);
      end else begin
        wait_cnt[i] = 0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) wait_cnt[i] = 0;
    tick();
    tick();

    // Reset state
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_alu_sel",   64'(alu_sel),       64'd0);
    chk("rst_alu_a",     64'(alu_a),         64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;

    // Single ADD from requester 0
    bus.req_valid = 4'b0001;
    set_req(0, ADD, 32'd5, 32'd7);
    #1;
    chk("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t1_alu_a",     64'(alu_a),         64'd5);
    chk("t1_alu_b",     64'(alu_b),         64'd7);
    chk("t1_exec_vld",  64'(bus.rsp_valid), 64'd0);
    chk("t1_exec_rdy",  64'(bus.req_ready), 64'd0);
    tick();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_id",    64'(bus.rsp_id),    64'd0);
    chk("t1_rsp_data",  64'(bus.rsp_data),  64'd12);
    chk("t1_rsp_err",   64'(bus.rsp_err),   64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_consumed",  64'(bus.rsp_valid), 64'd0);

    // All four valid back to back: grants 0,1,2,3,0 with no idle bubble
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, ADD, 32'(i), 32'd100);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_grant", 64'(bus.req_ready), 64'd1 << exp_g[k]);
      if (k > 0) begin
        chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2_rsp_id",    64'(bus.rsp_id),    64'(exp_g[k-1]));
        chk("t2_rsp_data",  64'(bus.rsp_data),  64'(100 + exp_g[k-1]));
      end
      tick();
      chk("t2_exec_vld", 64'(bus.rsp_valid), 64'd0);
      chk("t2_exec_a",   64'(alu_a),         64'(exp_g[k]));
      tick();
    end
    chk("t2_last_id",   64'(bus.rsp_id),   64'd0);
    chk("t2_last_data", 64'(bus.rsp_data), 64'd100);
    bus.req_valid = '0;
    tick();
    chk("t2_idle_vld", 64'(bus.rsp_valid), 64'd0);

    // Back-pressure: SUB from requester 2 held for five cycles, requester 1 waiting
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    set_req(2, SUB, 32'd3, 32'd5);
    #1;
    chk("t3_ready2", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = 4'b0010;
    set_req(1, ADD, 32'd1, 32'd1);
    #1;
    chk("t3_exec_rdy", 64'(bus.req_ready), 64'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_vld",  64'(bus.rsp_valid), 64'd1);
      chk("t3_hold_data", 64'(bus.rsp_data),  64'hFFFF_FFFE);
      chk("t3_hold_id",   64'(bus.rsp_id),    64'd2);
      chk("t3_hold_rdy",  64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    chk("t3_exec_vld", 64'(bus.rsp_valid), 64'd0);
    chk("t3_exec_a",   64'(alu_a),         64'd1);
    tick();
    chk("t3_rsp_id",   64'(bus.rsp_id),   64'd1);
    chk("t3_rsp_data", 64'(bus.rsp_data), 64'd2);
    tick();

    // Illegal select then a legal SRA from requester 3
    bus.req_valid = 4'b1000;
    set_req(3, 4'b1110, 32'd1, 32'd2);
    #1;
    chk("t4_ready3", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = '0;
    chk("t4_alu_sel", 64'(alu_sel), 64'd14);
    tick();
    chk("t4_err",      64'(bus.rsp_err),  64'd1);
    chk("t4_err_data", 64'(bus.rsp_data), 64'd0);
    chk("t4_err_id",   64'(bus.rsp_id),   64'd3);
    bus.req_valid = 4'b1000;
    set_req(3, SRA, 32'h8000_0000, 32'd4);
    #1;
    chk("t4_ready_b2b", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = '0;
    chk("t4_exec_vld", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("t4_sra_data", 64'(bus.rsp_data), 64'hF800_0000);
    chk("t4_sra_err",  64'(bus.rsp_err),  64'd0);
    tick();

    // Reset while an op is in EXEC
    bus.req_valid = 4'b0010;
    set_req(1, ADD, 32'd2, 32'd3);
    #1;
    chk("t5_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    rst_n = 1'b0;
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_vld", 64'(bus.rsp_valid), 64'd0);
    chk("t5_rst_a",   64'(alu_a),         64'd0);
    tick();
    chk("t5_no_rsp",  64'(bus.rsp_valid), 64'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("t5_grant0", 64'(bus.req_ready), 64'h1);
    bus.req_valid = '0;

    // Fairness: requester 3 gets in on the second accept despite requester 0 always valid
    bus.req_valid = 4'b1001;
    set_req(0, XOR, 32'hF0, 32'hFF);
    set_req(3, OR, 32'd1, 32'd2);
    #1;
    chk("t6_grant0", 64'(bus.req_ready), 64'h1);
    tick();
    tick();
    chk("t6_data0", 64'(bus.rsp_data), 64'h0F);
    #1;
    chk("t6_grant3", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = 4'b0001;
    tick();
    chk("t6_id3",   64'(bus.rsp_id),   64'd3);
    chk("t6_data3", 64'(bus.rsp_data), 64'd3);
    bus.req_valid = '0;
    tick();

    // Random traffic with scoreboard and starvation bound
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          bus.req_valid[i] = 1'b1;
          set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      sb_step();
      tick();
      bus.req_valid = bus.req_valid & ~acc;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      sb_step();
      tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
